mem_access_ctrl: RTL
====================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: rst  input  1  reset, asynchronous and active-high.
REQ-003 SHALL: req_valid  input  1  pipeline request strobe; sampled only in IDLE.
REQ-004 SHALL: req_wr  input  1  1 = store, 0 = load.
REQ-005 SHALL: req_size  input  2  00 byte, 01 half, 10 word; 11 reserved, treated as error.
REQ-006 SHALL: req_unsigned  input  1  zero-extend sub-word loads when 1, sign-extend when 0.
REQ-007 SHALL: req_addr  input  16  byte address.
REQ-008 SHALL: req_wdata  input  32  store data, right-justified.
REQ-009 SHALL: busy  output  1  stall to pipeline; high whenever state != IDLE.
REQ-010 SHALL: resp_valid  output  1  one-cycle completion pulse.
REQ-011 SHALL: resp_rdata  output  32  extended load data, valid with resp_valid; 0 for stores and errors.
REQ-012 SHALL: resp_err  output  1  misalignment, reserved size or memory err, valid with resp_valid.
REQ-013 SHALL: mem_addr  output  16  word-aligned address {lat_addr[15:2],2'b00}.
REQ-014 SHALL: mem_enable, mem_wr  output  1 each  memory request and write qualifier.
REQ-015 SHALL: mem_data_in  output  32  write word; 0 unless state is WR.
REQ-016 SHALL: mem_data_out  input  32  little-endian read word; byte at offset k occupies bits 8k+7:8k.
REQ-017 SHALL: mem_ready, mem_err  input  1 each  access-completed flag and memory error flag from the stalling memory.
REQ-018 SHALL: stall_cnt  output  16  saturating count of cycles spent with mem_enable=1 and mem_ready=0.

Function
REQ-019 SHALL: states IDLE, RD, RMW_RD, WR, RESP.
REQ-020 SHALL: IDLE with req_valid latches all req_* fields and decodes the next state. A misaligned request (half with addr[0]=1, word with addr[1:0]!=0) or size 11 goes to RESP with err set. A load goes to RD. A word store goes to WR with data=req_wdata. A byte or half store goes to RMW_RD.
REQ-021 SHALL: RD, RMW_RD and WR drive mem_enable=1; only WR drives mem_wr=1; IDLE and RESP drive mem_enable=0.
REQ-022 SHALL: while mem_ready=0, stay in the current state with mem_addr, mem_wr and mem_data_in held constant; no timeout.
REQ-023 SHALL: in RD with mem_ready=1, capture mem_data_out, then select and extend the lane addressed by lat_addr[1:0] and req_size, then go to RESP.
REQ-024 SHALL: in RMW_RD with mem_ready=1, merge the low byte or half of lat_wdata into the captured word at the offset lane, keep the other bytes unchanged, then go to WR.
REQ-025 SHALL: in WR with mem_ready=1, go to RESP.
REQ-026 SHALL: mem_err=1 coincident with mem_ready=1 in any access state aborts the access, skips WR, and goes to RESP with err set.
REQ-027 SHALL: RESP asserts resp_valid=1 for exactly one cycle, then returns to IDLE; busy drops in the same cycle as the IDLE entry.
REQ-028 SHALL: minimum latency from acceptance to resp_valid is 2 cycles for a load, 2 for a word store, 3 for an RMW store, and 1 for an error.
REQ-029 SHALL: stall_cnt saturates at 16'hFFFF and is cleared only by rst.
REQ-030 SHALL: req_valid is ignored while busy=1, so no second request is queued.

Reset
REQ-031 SHALL: rst=1 immediately forces IDLE and sets busy, resp_valid, resp_rdata, resp_err, mem_enable, mem_wr, mem_addr, mem_data_in, stall_cnt and all latched registers to 0.
REQ-032 SHALL: rst asserted mid-access abandons the access, including any RMW in progress, and produces no resp_valid.

Structure
REQ-033 SHALL: a shared package mem_ctrl_pkg holds the state enum, the req_size codes and the data width constants.
REQ-034 SHALL: a combinational sub-module mem_lane_align performs lane extract, sign/zero extension and store merge.

Verification
REQ-035 SHALL: with memory word at 0x0010 = 0x8899AABB, load byte signed at 0x0011 with no stall gives resp_rdata=0xFFFFFFAA two cycles after acceptance.
REQ-036 SHALL: half store 0x1234 to 0x0012 over word 0x8899AABB produces a read then a write of 0x1234AABB at mem_addr 0x0010, and a subsequent unsigned half load at 0x0012 returns 0x00001234.
REQ-037 SHALL: a word load at 0x0002 gives resp_err=1 one cycle after acceptance with mem_enable never asserted.
REQ-038 SHALL: a word load with mem_ready low for 5 cycles holds mem_addr and mem_enable stable, increments stall_cnt by 5 and gives resp_valid 7 cycles after acceptance.
REQ-039 SHALL: rst asserted in the WR state of a byte store causes no write on the following edges, all outputs to read 0 and no resp_valid.
REQ-040 SHALL: a second req_valid asserted while busy=1 is dropped, and exactly one resp_valid occurs.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the load/store memory access controller.
package mem_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 16;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_RMW_RD,
    ST_WR,
    ST_RESP
  } state_t;

  // Misaligned halves/words and the reserved size code are all rejected up front.
  function automatic logic req_bad(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SZ_BYTE: req_bad = 1'b0;
      SZ_HALF: req_bad = offset[0];
      SZ_WORD: req_bad = (offset != 2'b00);
      default: req_bad = 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane logic: load extract with sign/zero extension, and store merge.
module mem_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        offset,
  input  logic [1:0]        size,
  input  logic              is_unsigned,
  input  logic [15:0]       store_data,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged
);
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = word[7:0];
    case (offset)
      2'd1:    lane_b = word[15:8];
      2'd2:    lane_b = word[23:16];
      2'd3:    lane_b = word[31:24];
      default: lane_b = word[7:0];
    endcase
    lane_h = offset[1] ? word[31:16] : word[15:0];

    load_data = word;
    case (size)
      SZ_BYTE: load_data = {{24{~is_unsigned & lane_b[7]}}, lane_b};
      SZ_HALF: load_data = {{16{~is_unsigned & lane_h[15]}}, lane_h};
      default: load_data = word;
    endcase

    merged = word;
    if (size == SZ_BYTE) begin
      case (offset)
        2'd1:    merged[15:8]  = store_data[7:0];
        2'd2:    merged[23:16] = store_data[7:0];
        2'd3:    merged[31:24] = store_data[7:0];
        default: merged[7:0]   = store_data[7:0];
      endcase
    end else if (size == SZ_HALF) begin
      if (offset[1]) merged[31:16] = store_data;
      else           merged[15:0]  = store_data;
    end
  end
endmodule

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store controller in front of a stalling word memory;
// sub-word stores are done as read-modify-write.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              busy,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_enable,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  input  logic              mem_ready,
  input  logic              mem_err,
  output logic [15:0]       stall_cnt
);
  state_t            state;
  logic [ADDR_W-1:0] lat_addr;
  logic [1:0]        lat_size;
  logic              lat_unsigned;
  logic [15:0]       lat_wdata;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merged;

  assign mem_addr = {lat_addr[ADDR_W-1:2], 2'b00};

  mem_lane_align u_align (
    .word        (mem_data_out),
    .offset      (lat_addr[1:0]),
    .size        (lat_size),
    .is_unsigned (lat_unsigned),
    .store_data  (lat_wdata),
    .load_data   (load_data),
    .merged      (merged)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      lat_addr     <= '0;
      lat_size     <= '0;
      lat_unsigned <= 1'b0;
      lat_wdata    <= '0;
      busy         <= 1'b0;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      mem_enable   <= 1'b0;
      mem_wr       <= 1'b0;
      mem_data_in  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_addr     <= req_addr;
            lat_size     <= req_size;
            lat_unsigned <= req_unsigned;
            lat_wdata    <= req_wdata[15:0];
            busy         <= 1'b1;
            if (req_bad(req_size, req_addr[1:0])) begin
              state      <= ST_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else if (!req_wr) begin
              state      <= ST_RD;
              mem_enable <= 1'b1;
            end else if (req_size == SZ_WORD) begin
              state       <= ST_WR;
              mem_enable  <= 1'b1;
              mem_wr      <= 1'b1;
              mem_data_in <= req_wdata;
            end else begin
              state      <= ST_RMW_RD;
              mem_enable <= 1'b1;
            end
          end
        end
        ST_RD: begin
          if (mem_ready) begin
            state      <= ST_RESP;
            mem_enable <= 1'b0;
            resp_valid <= 1'b1;
            resp_err   <= mem_err;
            resp_rdata <= mem_err ? '0 : load_data;
          end
        end
        ST_RMW_RD: begin
          if (mem_ready) begin
            if (mem_err) begin
              state      <= ST_RESP;
              mem_enable <= 1'b0;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              state       <= ST_WR;
              mem_wr      <= 1'b1;
              mem_data_in <= merged;
            end
          end
        end
        ST_WR: begin
          if (mem_ready) begin
            state       <= ST_RESP;
            mem_enable  <= 1'b0;
            mem_wr      <= 1'b0;
            mem_data_in <= '0;
            resp_valid  <= 1'b1;
            resp_err    <= mem_err;
          end
        end
        ST_RESP: begin
          state      <= ST_IDLE;
          busy       <= 1'b0;
          resp_valid <= 1'b0;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        default: begin
          state       <= ST_IDLE;
          busy        <= 1'b0;
          resp_valid  <= 1'b0;
          resp_err    <= 1'b0;
          resp_rdata  <= '0;
          mem_enable  <= 1'b0;
          mem_wr      <= 1'b0;
          mem_data_in <= '0;
        end
      endcase
    end
  end

  // Counts every cycle an issued access is held off by the memory.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (mem_enable && !mem_ready && stall_cnt != 16'hFFFF) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
endmodule
